// File: rtl/hc_sr_pkg.sv
// hc_sr_pkg: shared constants and FSM state encoding for the HC-SR04 ranging path.
package hc_sr_pkg;

  // FSM state encoding, kept as plain constants for legacy compatibility
  typedef logic [2:0] state_t;
  localparam state_t IDLE    = 3'd0;
  localparam state_t ARMED   = 3'd1;
  localparam state_t MEASURE = 3'd2;
  localparam state_t CALC    = 3'd3;
  localparam state_t OUT     = 3'd4;
  localparam state_t TMO     = 3'd5;

  // Distance scale: mm = (us * K_MM + ROUND_MM) >> 16, about 0.170 mm/us
  localparam int unsigned K_MM_DEF         = 11141;
  localparam int unsigned ROUND_MM         = 32768;

  localparam int unsigned TIMEOUT_US_DEF   = 38000;
  localparam int unsigned CLK_TICKS_US_DEF = 50;

endpackage

// File: rtl/hc_sr_us_tick.sv
// hc_sr_us_tick: microsecond prescaler. Counts 0..CLK_TICKS_US-1 and flags the
// last count as a one-cycle tick. clr_i restarts the count at zero.
module hc_sr_us_tick #(
  parameter int unsigned CLK_TICKS_US = 50
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (CLK_TICKS_US > 1) ? $clog2(CLK_TICKS_US) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_TICKS_US - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrap at LAST, restart on clear
  always_comb begin
    tick_o = (cnt_q == LAST);
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
    if (clr_i) cnt_d = '0;
  end

  // Prescaler register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hc_sr_echo_meas.sv
// hc_sr_echo_meas: times the HC-SR04 echo pulse in 1 us ticks and converts the
// width to millimetres; flags timeouts. Define HC_SR_AVG4_EN to publish the
// average of the last four valid results instead of the raw value.
module hc_sr_echo_meas
  import hc_sr_pkg::*;
#(
  parameter int unsigned CLK_TICKS_US = CLK_TICKS_US_DEF,
  parameter int unsigned TIMEOUT_US   = TIMEOUT_US_DEF,
  parameter int unsigned K_MM         = K_MM_DEF
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        meas_start,
  input  logic        echo,
  output logic        busy,
  output logic [15:0] dist_mm,
  output logic        dist_vld,
  output logic        dist_err
);

  localparam logic [15:0] TMO_CNT = 16'(TIMEOUT_US);

  logic        sync1_q, sync2_q, prev_q;
  logic        rise, fall;
  state_t      state_q, state_d;
  logic [15:0] us_cnt_q, us_cnt_d, us_inc;
  logic [15:0] cap_q, cap_d;
  logic [29:0] prod_q, prod_d;
  logic [13:0] dist_q;
  logic        vld_q, err_q;
  logic        tick, tick_clr, pend;

  // Two-stage echo synchronizer plus previous value for edge detection
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= echo;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  // Prescaler held at zero while idle so the arm timeout counts whole
  // microseconds from arming; restarted again when the echo rises.
  assign tick_clr = (state_q == IDLE) || ((state_q == ARMED) && rise);

  hc_sr_us_tick #(
    .CLK_TICKS_US(CLK_TICKS_US)
  ) u_tick (
    .clk_i (Clk),
    .rst_ni(Rst_n),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  // Saturating microsecond count
  always_comb begin
    us_inc = us_cnt_q;
    if (tick && (us_cnt_q != TMO_CNT)) us_inc = us_cnt_q + 16'd1;
  end

  // FSM next-state; timeout is taken on the same edge the count reaches the
  // limit, and it wins over a simultaneous falling edge.
  always_comb begin
    state_d  = state_q;
    us_cnt_d = us_inc;
    cap_d    = cap_q;
    prod_d   = prod_q;
    case (state_q)
      IDLE: begin
        us_cnt_d = '0;
        if (meas_start && !pend) state_d = ARMED;
      end
      ARMED: begin
        if (rise) begin
          state_d  = MEASURE;
          us_cnt_d = '0;
        end else if (us_inc == TMO_CNT) begin
          state_d = TMO;
        end
      end
      MEASURE: begin
        if (us_inc == TMO_CNT) begin
          state_d = TMO;
        end else if (fall) begin
          state_d = CALC;
          cap_d   = us_inc;
        end
      end
      CALC: begin
        prod_d  = 30'(cap_q) * 30'(K_MM) + 30'(ROUND_MM);
        state_d = OUT;
      end
      OUT:     state_d = IDLE;
      TMO:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      us_cnt_q <= '0;
      cap_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      us_cnt_q <= us_cnt_d;
      cap_q    <= cap_d;
      prod_q   <= prod_d;
    end
  end

`ifdef HC_SR_AVG4_EN
  logic [3:0][13:0] hist_q;
  logic             fill_q, pend_q;
  logic [13:0]      raw_mm;
  logic [15:0]      hist_sum;

  assign raw_mm   = 14'(prod_q >> 16);
  assign hist_sum = 16'(hist_q[0]) + 16'(hist_q[1]) + 16'(hist_q[2]) + 16'(hist_q[3]);
  assign pend     = pend_q;

  // History of valid results; first result after reset or timeout fills all slots
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      hist_q <= '0;
      fill_q <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      pend_q <= (state_q == OUT);
      if (state_q == OUT) begin
        if (fill_q) hist_q <= {4{raw_mm}};
        else        hist_q <= {hist_q[2:0], raw_mm};
        fill_q <= 1'b0;
      end else if (state_q == TMO) begin
        fill_q <= 1'b1;
      end
    end
  end
`else
  assign pend = 1'b0;
`endif

  // Result publication: distance, valid strobe and sticky error
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      dist_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
`ifdef HC_SR_AVG4_EN
      if (pend_q) begin
        dist_q <= 14'(hist_sum >> 2);
        err_q  <= 1'b0;
        vld_q  <= 1'b1;
      end
`else
      if (state_q == OUT) begin
        dist_q <= 14'(prod_q >> 16);
        err_q  <= 1'b0;
        vld_q  <= 1'b1;
      end
`endif
      if (state_q == TMO) begin
        err_q <= 1'b1;
        vld_q <= 1'b1;
      end
    end
  end

  assign busy     = (state_q != IDLE) || pend || vld_q;
  assign dist_mm  = {2'b00, dist_q};
  assign dist_vld = vld_q;
  assign dist_err = err_q;

endmodule

// File: tb/tb_hc_sr_echo_meas.sv
// tb_hc_sr_echo_meas: directed bench for hc_sr_echo_meas with a shortened
// prescaler and timeout so full timeouts fit in a short run.
`timescale 1ns/1ps
module tb_hc_sr_echo_meas;

  localparam int unsigned NT = 3;     // clocks per us
  localparam int unsigned TO = 3000;  // timeout in us
`ifdef HC_SR_AVG4_EN
  localparam int unsigned LAT = 6;
`else
  localparam int unsigned LAT = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meas_start = 1'b0;
  logic        echo = 1'b0;
  logic        busy, dist_vld, dist_err;
  logic [15:0] dist_mm;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned vld_total = 0;
  int unsigned last_mm = 0;

  always #10 clk = ~clk;

  hc_sr_echo_meas #(
    .CLK_TICKS_US(NT),
    .TIMEOUT_US  (TO),
    .K_MM        (11141)
  ) dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .meas_start(meas_start),
    .echo      (echo),
    .busy      (busy),
    .dist_mm   (dist_mm),
    .dist_vld  (dist_vld),
    .dist_err  (dist_err)
  );

  always @(negedge clk) if (dist_vld === 1'b1) vld_total <= vld_total + 1;

  typedef struct {
    int unsigned width_clk;
    int unsigned exp_raw;
  } vec_t;

`ifdef HC_SR_AVG4_EN
  int unsigned h[4];
  bit          fill = 1'b1;
`endif

  task automatic model_clear();
`ifdef HC_SR_AVG4_EN
    fill = 1'b1;
`endif
  endtask

  function automatic int unsigned publish(input int unsigned raw);
`ifdef HC_SR_AVG4_EN
    if (fill) begin
      for (int i = 0; i < 4; i++) h[i] = raw;
      fill = 1'b0;
    end else begin
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = raw;
    end
    return (h[0] + h[1] + h[2] + h[3]) >> 2;
`else
    return raw;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic run_pulse(input string tag, input int unsigned width, input int unsigned raw);
    int unsigned lat, v0, exp_mm;
    exp_mm = publish(raw);
    v0 = vld_total;
    @(negedge clk); meas_start = 1'b1;
    @(negedge clk); meas_start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    repeat (4) @(negedge clk);
    echo = 1'b1;
    repeat (width) @(negedge clk);
    echo = 1'b0;
    lat = 0;
    while (lat < 40 && dist_vld !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_mm"}, dist_mm, exp_mm);
    check({tag, "_err"}, dist_err, 0);
    check({tag, "_busy_with_vld"}, busy, 1);
    @(negedge clk);
    check({tag, "_vld_fall"}, dist_vld, 0);
    check({tag, "_busy_fall"}, busy, 0);
    repeat (3) @(negedge clk);
    check({tag, "_vld_count"}, vld_total - v0, 1);
    last_mm = exp_mm;
  endtask

  vec_t vecs[6];
  vec_t avg_seq[4];

  initial begin
    int unsigned c, v0;

    vecs[0] = '{2500 * NT, 425};
    vecs[1] = '{1000 * NT, 170};
    vecs[2] = '{1, 0};            // sub-microsecond pulse
    vecs[3] = '{100 * NT, 17};    // rounds just below .5
    vecs[4] = '{2999 * NT, 510};  // longest pulse short of timeout
    vecs[5] = '{2941 * NT, 500};

    avg_seq[0] = '{1000 * NT, 170};
    avg_seq[1] = '{1000 * NT, 170};
    avg_seq[2] = '{1000 * NT, 170};
    avg_seq[3] = '{2500 * NT, 425};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mm", dist_mm, 0);
    check("rst_vld", dist_vld, 0);
    check("rst_err", dist_err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int unsigned i = 0; i < 6; i++)
      run_pulse($sformatf("vec%0d", i), vecs[i].width_clk, vecs[i].exp_raw);

    // Echo never rises: timeout from ARMED
    v0 = vld_total;
    @(negedge clk); meas_start = 1'b1;
    @(negedge clk); meas_start = 1'b0;
    c = 1;
    while (c < TO * NT + 60 && dist_vld !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    check("tmo_arm_latency", c, TO * NT + 2);
    check("tmo_arm_err", dist_err, 1);
    check("tmo_arm_mm_hold", dist_mm, last_mm);
    repeat (4) @(negedge clk);
    check("tmo_arm_vld_count", vld_total - v0, 1);
    check("tmo_arm_busy", busy, 0);
    model_clear();

    // Next valid result clears the error
    run_pulse("after_tmo", 1000 * NT, 170);

    // Echo stuck high; meas_start pulsed during MEASURE must be ignored
    v0 = vld_total;
    @(negedge clk); meas_start = 1'b1;
    @(negedge clk); meas_start = 1'b0;
    repeat (4) @(negedge clk);
    echo = 1'b1;
    c = 0;
    repeat (10) begin @(negedge clk); c++; end
    meas_start = 1'b1;
    @(negedge clk); c++;
    meas_start = 1'b0;
    while (c < TO * NT + 60 && dist_vld !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    check("tmo_meas_latency", c, TO * NT + 4);
    check("tmo_meas_err", dist_err, 1);
    check("tmo_meas_mm_hold", dist_mm, last_mm);
    echo = 1'b0;
    repeat (10) @(negedge clk);
    check("tmo_meas_vld_count", vld_total - v0, 1);
    check("tmo_meas_busy", busy, 0);
    model_clear();

    // Reset mid-measurement: no result for the aborted pulse
    @(negedge clk); meas_start = 1'b1;
    @(negedge clk); meas_start = 1'b0;
    repeat (4) @(negedge clk);
    echo = 1'b1;
    repeat (1200 * NT) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_mm", dist_mm, 0);
    check("midrst_vld", dist_vld, 0);
    check("midrst_err", dist_err, 0);
    rst_n = 1'b1;
    v0 = vld_total;
    repeat (500 * NT) @(negedge clk);
    echo = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_vld", vld_total - v0, 0);
    check("midrst_idle", busy, 0);
    model_clear();
    last_mm = 0;
    run_pulse("after_rst", 2500 * NT, 425);

    // Fresh history, then the averaging sequence (raw values in default build)
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    for (int unsigned i = 0; i < 4; i++)
      run_pulse($sformatf("seq%0d", i), avg_seq[i].width_clk, avg_seq[i].exp_raw);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

endmodule

// File: doc/hc_sr_echo_meas.md
# hc_sr_echo_meas

Echo-pulse measurement stage for the HC-SR04 ranging path. Sits directly downstream of the trigger generator: armed by the trigger block's end-of-pulse strobe, it times the sensor's echo pulse in 1 µs ticks and converts the width to millimetres. It also flags timeouts. Its distance output feeds the BCD/seven-segment display stage.

## Interface
- CLK_TICKS_US, 50, system clocks per microsecond (50 MHz)
- TIMEOUT_US, 38000, maximum µs waited for echo rise and maximum echo width
- K_MM, 11141, distance scale: mm = (us·K_MM + 32768) >> 16 (≈0.170 mm/µs)

Ports:
- Clk  input  1  system clock, 50 MHz
- Rst_n  input  1  reset; synchronous, active-low
- meas_start  input  1  one-cycle strobe from trigger block at end of trig pulse
- echo  input  1  raw sensor echo, asynchronous
- busy  output  1  high while not IDLE
- dist_mm  output  16  last result in mm, zero-extended from 14 bits
- dist_vld  output  1  one-cycle strobe when a measurement completes (valid or error)
- dist_err  output  1  level; set on timeout, cleared by next valid result

## Operation
- echo passes through 2-FF synchronizer, then a previous-value register for edge detect.
- Prescaler counts 0..CLK_TICKS_US-1 and emits a 1 µs tick. It clears on ARMED→MEASURE, so only full microseconds are counted.
- us_cnt: 16 bits, saturating at TIMEOUT_US.
- FSM states:
  - IDLE: meas_start → ARMED, us_cnt=0.
  - ARMED: synced rising edge → MEASURE, us_cnt=0. us_cnt reaching TIMEOUT_US → TMO.
  - MEASURE: synced falling edge → CALC, capturing us_cnt. us_cnt reaching TIMEOUT_US → TMO.
  - CALC: registers product us_cnt·K_MM (30 bits) plus 32768 → OUT.
  - OUT: dist_mm ← product[29:16]; dist_err←0; dist_vld=1 → IDLE.
  - TMO: dist_vld=1; dist_err←1; dist_mm holds previous value → IDLE.
- meas_start outside IDLE is ignored.
- echo already high when armed: no rising edge is seen, so the FSM ends in TMO.
- Glitch-free behaviour assumed after synchronizer; no additional debounce.

## Timing
- Reset values: busy=0, dist_mm=0, dist_vld=0, dist_err=0; FSM=IDLE; all counters 0.
- Rst_n low at any edge, including mid-measurement, forces reset values on that edge. No result is emitted for the aborted measurement.
- Latency: if edge k is the first to sample echo low, dist_vld is high in the cycle after edge k+4.
- Timeout: dist_vld is high in the cycle after the edge where us_cnt reaches TIMEOUT_US, plus 1.
- busy rises the edge after meas_start and falls the same edge dist_vld falls.
- Width measurement is accurate to ±1 µs (sync jitter ±1 clock both edges).
- Result range: 0..6460 mm. A 0 µs pulse gives dist_mm=0 with dist_vld.

## Configuration
- HC_SR_AVG4_EN defined:
  - OUT publishes the average of the last four valid raw results: (sum of 4) >> 2, 16-bit sum.
  - After reset or any TMO, the first valid raw value fills all four history slots, so the first output equals the raw value.
  - Adds one pipeline stage; latency becomes k+5.
  - TMO does not update history.
- Undefined: raw result published directly, no history registers.

## Structure
- Shared package hc_sr_pkg holds:
  - FSM state typedef (IDLE, ARMED, MEASURE, CALC, OUT, TMO)
  - K_MM and rounding constant 32768
  - default TIMEOUT_US and CLK_TICKS_US
- Sub-module hc_sr_us_tick: prescaler with sync clear input and tick output; reused by the trigger block.

## Test plan
- meas_start, then echo high 2500 µs (125000 clocks) → dist_vld once, dist_mm=425, dist_err=0, latency 4 edges after fall.
- echo high 1000 µs → dist_mm=170; echo high 23529 µs → dist_mm=4000.
- meas_start, echo never rises → at 38000 µs dist_vld=1, dist_err=1, dist_mm unchanged (425). Next 1000 µs pulse → dist_err=0, dist_mm=170.
- echo held high past 38000 µs → TMO with dist_err=1. meas_start pulsed during MEASURE → ignored, single dist_vld.
- Rst_n low for 1 cycle at 1200 µs into a pulse → all outputs 0, no dist_vld. Following 2500 µs measurement → 425.
- HC_SR_AVG4_EN: pulses 1000, 1000, 1000, 2500 µs → dist_mm 170, 170, 170, 233. After a TMO, a 2500 µs pulse → 425.
